// File: rtl/freelist_ctrl_pkg.sv
// Shared constants and types for the physical-register free list.
// WAYS and PRF fall back to 4 and 64 when not supplied on the command line.
`ifndef WAYS
`define WAYS 4
`endif
`ifndef PRF
`define PRF 64
`endif

package freelist_ctrl_pkg;
    localparam int PRF_N      = `PRF;
    localparam int ARF_N      = 32;
    localparam int PR_IDX_W   = $clog2(PRF_N);
    localparam int FREE_CNT_W = $clog2(PRF_N + 1);

    typedef logic [PR_IDX_W-1:0] pr_idx_t;

    // Architectural registers 0..ARF-1 start mapped; everything above starts free.
    localparam logic [PRF_N-1:0] RESET_FREE_VEC = {{(PRF_N - ARF_N){1'b1}}, {ARF_N{1'b0}}};
endpackage

// File: rtl/freelist_pick_n.sv
// Combinational N-of-M picker: even picks take the lowest remaining free bit,
// odd picks the highest, each pick removed before the next is chosen.
module freelist_pick_n #(
    parameter int M = 64,
    parameter int N = 4,
    parameter int W = $clog2(M)
) (
    input  logic [M-1:0]        free_vec,
    output logic [N-1:0][W-1:0] pick_idx,
    output logic [N-1:0]        pick_valid
);
    logic [M-1:0] avail;

    always_comb begin
        avail      = free_vec;
        pick_idx   = '0;
        pick_valid = '0;
        for (int k = 0; k < N; k++) begin
            // The last hit in scan order wins, so scanning downward yields the lowest index.
            if ((k % 2) == 0) begin
                for (int i = M - 1; i >= 0; i--) begin
                    if (avail[i]) begin
                        pick_idx[k]   = W'(i);
                        pick_valid[k] = 1'b1;
                    end
                end
            end else begin
                for (int i = 0; i < M; i++) begin
                    if (avail[i]) begin
                        pick_idx[k]   = W'(i);
                        pick_valid[k] = 1'b1;
                    end
                end
            end
            if (pick_valid[k]) begin
                avail[pick_idx[k]] = 1'b0;
            end
        end
    end
endmodule

// File: rtl/freelist_ctrl.sv
// Rename-stage free-list manager with speculative and architectural free vectors.
// Define FREELIST_CHECK_EN to build the sticky consistency checker behind fl_error.
`ifndef WAYS
`define WAYS 4
`endif

module freelist_ctrl
    import freelist_ctrl_pkg::*;
#(
    parameter int WAYS = `WAYS,
    parameter int PRF  = PRF_N,
    parameter int ARF  = ARF_N,
    parameter int PW   = $clog2(PRF)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [WAYS-1:0]           alloc_req,
    output logic [WAYS-1:0][PW-1:0]   alloc_pr,
    output logic [WAYS-1:0]           alloc_valid,
    output logic                      alloc_stall,
    input  logic [WAYS-1:0]           ret_en,
    input  logic [WAYS-1:0][PW-1:0]   ret_old_pr,
    input  logic [WAYS-1:0][PW-1:0]   ret_new_pr,
    input  logic                      squash,
    output logic [$clog2(PRF+1)-1:0]  free_count,
    output logic                      fl_error
);
    localparam int CW = $clog2(PRF + 1);
    localparam logic [PRF-1:0] RST_FREE = PRF'(RESET_FREE_VEC);

    logic [PRF-1:0]           spec_free_q, spec_free_d;
    logic [PRF-1:0]           arch_free_q, arch_free_d;
    logic [CW-1:0]            free_count_q, free_count_d;
    logic [WAYS-1:0][PW-1:0]  pick_idx;
    logic [WAYS-1:0]          pick_valid;
    logic [PRF-1:0]           granted_bits, released_bits, retired_new_bits;
    logic [CW-1:0]            n_req;

    freelist_pick_n #(.M(PRF), .N(WAYS), .W(PW)) u_pick (
        .free_vec   (spec_free_q),
        .pick_idx   (pick_idx),
        .pick_valid (pick_valid)
    );

    // Grants are all-or-nothing against the registered count; squash overrides everything.
    always_comb begin
        n_req        = CW'($countones(alloc_req));
        alloc_stall  = (n_req > free_count_q) && !squash;
        alloc_valid  = alloc_req & {WAYS{!alloc_stall && !squash}};
        alloc_pr     = '0;
        granted_bits = '0;
        for (int k = 0; k < WAYS; k++) begin
            if (alloc_valid[k] && pick_valid[k]) begin
                alloc_pr[k]               = pick_idx[k];
                granted_bits[pick_idx[k]] = 1'b1;
            end
        end
    end

    always_comb begin
        released_bits    = '0;
        retired_new_bits = '0;
        for (int k = 0; k < WAYS; k++) begin
            if (ret_en[k]) begin
                released_bits[ret_old_pr[k]]    = 1'b1;
                retired_new_bits[ret_new_pr[k]] = 1'b1;
            end
        end
        arch_free_d  = (arch_free_q | released_bits) & ~retired_new_bits;
        spec_free_d  = squash ? arch_free_d : ((spec_free_q & ~granted_bits) | released_bits);
        free_count_d = CW'($countones(spec_free_d));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            spec_free_q  <= RST_FREE;
            arch_free_q  <= RST_FREE;
            free_count_q <= CW'(PRF - ARF);
        end else begin
            spec_free_q  <= spec_free_d;
            arch_free_q  <= arch_free_d;
            free_count_q <= free_count_d;
        end
    end

    assign free_count = free_count_q;

`ifdef FREELIST_CHECK_EN
    logic err_q, err_d, err_event;

    // Flags double frees, duplicate releases in one cycle, and retiring an arch-free PR.
    always_comb begin
        err_event = 1'b0;
        for (int k = 0; k < WAYS; k++) begin
            if (ret_en[k]) begin
                if (spec_free_q[ret_old_pr[k]]) err_event = 1'b1;
                if (arch_free_q[ret_new_pr[k]]) err_event = 1'b1;
                for (int j = 0; j < k; j++) begin
                    if (ret_en[j] && (ret_old_pr[j] == ret_old_pr[k])) err_event = 1'b1;
                end
            end
        end
        err_d = err_q | err_event;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset_n && err_event) begin
            $error("freelist_ctrl: free-list consistency violation");
        end
    end

    assign fl_error = err_q;
`else
    assign fl_error = 1'b0;
`endif
endmodule

// File: tb/tb_freelist_ctrl.sv
// Scoreboard bench for freelist_ctrl: the driver queues hand-computed expectations
// per cycle and an independent monitor compares them on the falling edge.
module tb_freelist_ctrl;
    localparam int WAYS = 4;
    localparam int PRF  = 64;
    localparam int ARF  = 32;
    localparam int PW   = 6;
    localparam int CW   = 7;
`ifdef FREELIST_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    typedef logic [WAYS-1:0][PW-1:0] prv_t;
    typedef struct {
        int             id;
        logic [WAYS-1:0] valid;
        prv_t           pr;
        logic           stall;
        logic [CW-1:0]  count;
        logic           chk_err;
        logic           err;
    } exp_t;

    logic                    clock = 1'b0;
    logic                    reset_n;
    logic [WAYS-1:0]         alloc_req;
    prv_t                    alloc_pr;
    logic [WAYS-1:0]         alloc_valid;
    logic                    alloc_stall;
    logic [WAYS-1:0]         ret_en;
    prv_t                    ret_old_pr;
    prv_t                    ret_new_pr;
    logic                    squash;
    logic [CW-1:0]           free_count;
    logic                    fl_error;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   step_id = 0;
    prv_t zero_pr = '0;

    always #5 clock = ~clock;

    freelist_ctrl #(.WAYS(WAYS), .PRF(PRF), .ARF(ARF), .PW(PW)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .alloc_req   (alloc_req),
        .alloc_pr    (alloc_pr),
        .alloc_valid (alloc_valid),
        .alloc_stall (alloc_stall),
        .ret_en      (ret_en),
        .ret_old_pr  (ret_old_pr),
        .ret_new_pr  (ret_new_pr),
        .squash      (squash),
        .free_count  (free_count),
        .fl_error    (fl_error)
    );

    function automatic prv_t prs(input int a0, input int a1, input int a2, input int a3);
        prv_t p;
        p[0] = PW'(a0);
        p[1] = PW'(a1);
        p[2] = PW'(a2);
        p[3] = PW'(a3);
        return p;
    endfunction

    task automatic check_field(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s step %0d: got %0h expected %0h", name, id, act, exp);
    endtask

    task automatic check_output(input exp_t e);
        check_field("alloc_valid", e.id, 32'(alloc_valid), 32'(e.valid));
        check_field("alloc_pr", e.id, 32'(alloc_pr), 32'(e.pr));
        check_field("alloc_stall", e.id, 32'(alloc_stall), 32'(e.stall));
        check_field("free_count", e.id, 32'(free_count), 32'(e.count));
        if (e.chk_err) check_field("fl_error", e.id, 32'(fl_error), 32'(e.err));
    endtask

    task automatic apply_stimulus(input logic [WAYS-1:0] req, input logic [WAYS-1:0] ren,
                                  input prv_t old_pr, input prv_t new_pr, input logic sq,
                                  input logic [WAYS-1:0] e_valid, input prv_t e_pr,
                                  input logic e_stall, input int e_count,
                                  input logic chk_err = 1'b0, input logic e_err = 1'b0);
        exp_t e;
        @(posedge clock);
        #1;
        alloc_req  = req;
        ret_en     = ren;
        ret_old_pr = old_pr;
        ret_new_pr = new_pr;
        squash     = sq;
        step_id++;
        e.id      = step_id;
        e.valid   = e_valid;
        e.pr      = e_pr;
        e.stall   = e_stall;
        e.count   = CW'(e_count);
        e.chk_err = chk_err;
        e.err     = e_err;
        exp_q.push_back(e);
    endtask

    task automatic alloc_step(input logic [WAYS-1:0] req, input logic [WAYS-1:0] e_valid,
                              input prv_t e_pr, input logic e_stall, input int e_count);
        apply_stimulus(req, '0, zero_pr, zero_pr, 1'b0, e_valid, e_pr, e_stall, e_count);
    endtask

    // Asserted mid-cycle so the monitor sees reset values before any clock edge.
    task automatic pulse_reset();
        exp_t e;
        @(posedge clock);
        #1;
        reset_n    = 1'b0;
        alloc_req  = '0;
        ret_en     = '0;
        ret_old_pr = '0;
        ret_new_pr = '0;
        squash     = 1'b0;
        step_id++;
        e.id      = step_id;
        e.valid   = '0;
        e.pr      = '0;
        e.stall   = 1'b0;
        e.count   = CW'(PRF - ARF);
        e.chk_err = 1'b1;
        e.err     = 1'b0;
        exp_q.push_back(e);
        @(negedge clock);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output(e);
            end
        end
    end

    initial begin
        int wait_cycles;
        reset_n    = 1'b0;
        alloc_req  = '0;
        ret_en     = '0;
        ret_old_pr = '0;
        ret_new_pr = '0;
        squash     = 1'b0;
        #12;
        reset_n = 1'b1;

        // Reset state, single grant
        apply_stimulus('0, '0, zero_pr, zero_pr, 1'b0, '0, zero_pr, 1'b0, 32, 1'b1, 1'b0);
        alloc_step(4'b0001, 4'b0001, prs(32, 0, 0, 0), 1'b0, 32);
        alloc_step(4'b0000, 4'b0000, zero_pr, 1'b0, 31);

        // Two lanes: lowest then highest
        pulse_reset();
        alloc_step(4'b0011, 4'b0011, prs(32, 63, 0, 0), 1'b0, 32);
        alloc_step(4'b0000, 4'b0000, zero_pr, 1'b0, 30);

        // Drain from both ends, then stall and empty
        for (int j = 0; j < 7; j++) begin
            alloc_step(4'b1111, 4'b1111, prs(33 + 2*j, 62 - 2*j, 34 + 2*j, 61 - 2*j), 1'b0, 30 - 4*j);
        end
        alloc_step(4'b0001, 4'b0001, prs(47, 0, 0, 0), 1'b0, 2);
        alloc_step(4'b0011, 4'b0000, zero_pr, 1'b1, 1);
        alloc_step(4'b0001, 4'b0001, prs(48, 0, 0, 0), 1'b0, 1);
        alloc_step(4'b0001, 4'b0000, zero_pr, 1'b1, 0);
        apply_stimulus(4'b0011, '0, zero_pr, zero_pr, 1'b1, '0, zero_pr, 1'b0, 0);
        alloc_step(4'b0000, 4'b0000, zero_pr, 1'b0, 32);

        // Sparse lanes, alloc+retire, release-to-reallocate, squash restore
        pulse_reset();
        alloc_step(4'b1111, 4'b1111, prs(32, 63, 33, 62), 1'b0, 32);
        alloc_step(4'b1111, 4'b1111, prs(34, 61, 35, 60), 1'b0, 28);
        alloc_step(4'b0011, 4'b0011, prs(36, 59, 0, 0), 1'b0, 24);
        alloc_step(4'b0101, 4'b0101, prs(37, 0, 38, 0), 1'b0, 22);
        alloc_step(4'b0001, 4'b0001, prs(39, 0, 0, 0), 1'b0, 20);
        alloc_step(4'b0001, 4'b0001, prs(40, 0, 0, 0), 1'b0, 19);
        apply_stimulus(4'b0001, 4'b0001, prs(5, 0, 0, 0), prs(40, 0, 0, 0), 1'b0,
                       4'b0001, prs(41, 0, 0, 0), 1'b0, 18);
        alloc_step(4'b0001, 4'b0001, prs(5, 0, 0, 0), 1'b0, 18);
        apply_stimulus(4'b1111, '0, zero_pr, zero_pr, 1'b1, '0, zero_pr, 1'b0, 17);
        alloc_step(4'b0011, 4'b0011, prs(5, 63, 0, 0), 1'b0, 32);

        // Squash after retirements, and squash in the same cycle as a retire
        pulse_reset();
        alloc_step(4'b1111, 4'b1111, prs(32, 63, 33, 62), 1'b0, 32);
        alloc_step(4'b1111, 4'b1111, prs(34, 61, 35, 60), 1'b0, 28);
        alloc_step(4'b0011, 4'b0011, prs(36, 59, 0, 0), 1'b0, 24);
        apply_stimulus('0, 4'b0011, prs(3, 7, 0, 0), prs(32, 63, 0, 0), 1'b0, '0, zero_pr, 1'b0, 22);
        apply_stimulus(4'b1111, '0, zero_pr, zero_pr, 1'b1, '0, zero_pr, 1'b0, 24);
        alloc_step(4'b0000, 4'b0000, zero_pr, 1'b0, 32);
        apply_stimulus('0, 4'b0001, prs(12, 0, 0, 0), prs(36, 0, 0, 0), 1'b1, '0, zero_pr, 1'b0, 32);
        alloc_step(4'b0111, 4'b0111, prs(3, 62, 7, 0), 1'b0, 32);

        // Double release of an already-free PR
        pulse_reset();
        apply_stimulus('0, 4'b0001, prs(50, 0, 0, 0), prs(0, 0, 0, 0), 1'b0, '0, zero_pr, 1'b0, 32);
        apply_stimulus('0, '0, zero_pr, zero_pr, 1'b0, '0, zero_pr, 1'b0, 32, 1'b1, EXP_ERR);
        apply_stimulus('0, '0, zero_pr, zero_pr, 1'b0, '0, zero_pr, 1'b0, 32, 1'b1, EXP_ERR);
        pulse_reset();

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clock);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            $display("[TB] FAIL drain: %0d expectations pending, expected 0", exp_q.size());
        end
        @(negedge clock);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
